// File: rtl/sat_pkg.sv
// Shared definitions for the sat_engine host side: default widths, loader FSM states
// and a one-hot helper.
package sat_pkg;

   localparam int NUM_CLAUSES_DEF      = 8;
   localparam int NUM_VARS_DEF         = 8;
   localparam int NUM_LVLS_DEF         = 8;
   localparam int WIDTH_LVL_DEF        = 16;
   localparam int WIDTH_VAR_STATES_DEF = 19;
   localparam int WIDTH_LVL_STATES_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_C  = 3'd1,
      ST_LOAD_ST = 3'd2,
      ST_START   = 3'd3,
      ST_WAIT    = 3'd4,
      ST_RDBK    = 3'd5,
      ST_FIN     = 3'd6
   } loader_state_t;

   // Wide enough for any clause-array size used here; callers cast to their width.
   function automatic logic [63:0] onehot(input int unsigned idx);
      onehot = 64'd1 << idx;
   endfunction

endpackage

// File: rtl/loader_row_ctr.sv
// Row sequencer shared by clause load and readback: issues rows 0..N-1 once per
// enable window and provides the one-cycle-delayed index/valid for the data phase.
module loader_row_ctr #(
   parameter int N   = 8,
   parameter int W_I = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   output logic           issue,
   output logic [W_I-1:0] idx,
   output logic           vld_d,
   output logic [W_I-1:0] idx_d,
   output logic           last_d
);

   logic spent;

   assign issue  = en && !spent;
   assign last_d = vld_d && (idx_d == W_I'(N - 1));

   // Counter stops at the last row; only leaving the enable window rewinds it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx   <= '0;
         idx_d <= '0;
         vld_d <= 1'b0;
         spent <= 1'b0;
      end else if (!en) begin
         idx   <= '0;
         idx_d <= '0;
         vld_d <= 1'b0;
         spent <= 1'b0;
      end else begin
         vld_d <= issue;
         idx_d <= idx;
         if (issue) begin
            if (idx == W_I'(N - 1)) spent <= 1'b1;
            else                    idx   <= idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sat_engine_loader.sv
// Host-side sequencer for one sat_engine bin run: load clauses and state lists,
// start the core, wait for completion, then read the clause array back to the store.
module sat_engine_loader
   import sat_pkg::*;
#(
   parameter int NUM_CLAUSES      = NUM_CLAUSES_DEF,
   parameter int NUM_VARS         = NUM_VARS_DEF,
   parameter int NUM_LVLS         = NUM_LVLS_DEF,
   parameter int WIDTH_LVL        = WIDTH_LVL_DEF,
   parameter int WIDTH_VAR_STATES = WIDTH_VAR_STATES_DEF,
   parameter int WIDTH_LVL_STATES = WIDTH_LVL_STATES_DEF,
   localparam int W_C  = NUM_VARS * 2,
   localparam int W_VS = WIDTH_VAR_STATES * NUM_VARS,
   localparam int W_LS = WIDTH_LVL_STATES * NUM_LVLS,
   localparam int W_I  = $clog2(NUM_CLAUSES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [WIDTH_LVL-1:0]   bin_num_i,
   input  logic [WIDTH_LVL-1:0]   load_lvl_i,
   input  logic [WIDTH_LVL-1:0]   base_lvl_i,
   input  logic [W_VS-1:0]        vs_i,
   input  logic [W_LS-1:0]        ls_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   sat_o,
   output logic                   unsat_o,
   output logic [WIDTH_LVL-1:0]   bkt_lvl_o,
   output logic [WIDTH_LVL-1:0]   cur_lvl_o,
   output logic [W_VS-1:0]        vs_o,
   output logic [W_LS-1:0]        ls_o,
   output logic                   mem_rd_o,
   output logic [W_I-1:0]         mem_idx_o,
   input  logic [W_C-1:0]         mem_rd_data_i,
   output logic                   mem_wr_o,
   output logic [W_C-1:0]         mem_wr_data_o,
   output logic [NUM_CLAUSES-1:0] wr_carray_o,
   output logic [W_C-1:0]         clause_o,
   output logic [NUM_CLAUSES-1:0] rd_carray_o,
   input  logic [W_C-1:0]         clause_i,
   output logic [NUM_VARS-1:0]    wr_var_states_o,
   output logic [W_VS-1:0]        vars_states_o,
   input  logic [W_VS-1:0]        vars_states_i,
   output logic [NUM_LVLS-1:0]    wr_lvl_states_o,
   output logic [W_LS-1:0]        lvl_states_o,
   input  logic [W_LS-1:0]        lvl_states_i,
   output logic                   start_core_o,
   output logic [WIDTH_LVL-1:0]   cur_bin_num_o,
   output logic [WIDTH_LVL-1:0]   load_lvl_o,
   output logic [WIDTH_LVL-1:0]   base_lvl_o,
   output logic                   base_lvl_en_o,
   input  logic                   done_core_i,
   input  logic                   sat_i,
   input  logic                   unsat_i,
   input  logic [WIDTH_LVL-1:0]   bkt_lvl_i,
   input  logic [WIDTH_LVL-1:0]   cur_lvl_i
);

   loader_state_t        state;
   logic [WIDTH_LVL-1:0] bin_q, load_lvl_q, base_lvl_q;
   logic [W_VS-1:0]      vs_q;
   logic [W_LS-1:0]      ls_q;

   logic           in_load, in_rdbk, in_hold;
   logic           row_issue, row_vld_d, row_last_d;
   logic [W_I-1:0] row_idx, row_idx_d;

   assign in_load = (state == ST_LOAD_C);
   assign in_rdbk = (state == ST_RDBK);
   assign in_hold = (state == ST_START) || (state == ST_WAIT) ||
                    (state == ST_RDBK)  || (state == ST_FIN);

   loader_row_ctr #(.N(NUM_CLAUSES), .W_I(W_I)) u_row_ctr (
      .clk    (clk),
      .rst    (rst),
      .en     (in_load || in_rdbk),
      .issue  (row_issue),
      .idx    (row_idx),
      .vld_d  (row_vld_d),
      .idx_d  (row_idx_d),
      .last_d (row_last_d)
   );

   // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         bin_q      <= '0;
         load_lvl_q <= '0;
         base_lvl_q <= '0;
         vs_q       <= '0;
         ls_q       <= '0;
         sat_o      <= 1'b0;
         unsat_o    <= 1'b0;
         bkt_lvl_o  <= '0;
         cur_lvl_o  <= '0;
         vs_o       <= '0;
         ls_o       <= '0;
      end else begin
         unique case (state)
            ST_IDLE: if (start_i) begin
               state      <= ST_LOAD_C;
               bin_q      <= bin_num_i;
               load_lvl_q <= load_lvl_i;
               base_lvl_q <= base_lvl_i;
               vs_q       <= vs_i;
               ls_q       <= ls_i;
            end
            ST_LOAD_C:  if (row_last_d) state <= ST_LOAD_ST;
            ST_LOAD_ST: state <= ST_START;
            ST_START:   state <= ST_WAIT;
            ST_WAIT: if (done_core_i) begin
               state     <= ST_RDBK;
               sat_o     <= sat_i;
               unsat_o   <= unsat_i;
               bkt_lvl_o <= bkt_lvl_i;
               cur_lvl_o <= cur_lvl_i;
            end
            ST_RDBK: if (row_last_d) begin
               state <= ST_FIN;
               vs_o  <= vars_states_i;
               ls_o  <= lvl_states_i;
            end
            ST_FIN:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy_o = (state != ST_IDLE) && (state != ST_FIN);
   assign done_o = (state == ST_FIN);

   // Store reads only during clause load, store writes only during readback.
   assign mem_rd_o      = in_load && row_issue;
   assign mem_wr_o      = in_rdbk && row_vld_d;
   assign mem_idx_o     = mem_rd_o ? row_idx : (mem_wr_o ? row_idx_d : '0);
   assign mem_wr_data_o = mem_wr_o ? clause_i : '0;

   assign wr_carray_o = (in_load && row_vld_d) ? NUM_CLAUSES'(onehot(row_idx_d)) : '0;
   assign clause_o    = (in_load && row_vld_d) ? mem_rd_data_i : '0;
   assign rd_carray_o = (in_rdbk && row_issue) ? NUM_CLAUSES'(onehot(row_idx)) : '0;

   assign wr_var_states_o = (state == ST_LOAD_ST) ? '1 : '0;
   assign wr_lvl_states_o = (state == ST_LOAD_ST) ? '1 : '0;
   assign vars_states_o   = (state == ST_LOAD_ST) ? vs_q : '0;
   assign lvl_states_o    = (state == ST_LOAD_ST) ? ls_q : '0;

   assign start_core_o  = (state == ST_START);
   assign base_lvl_en_o = (state == ST_START);
   assign cur_bin_num_o = in_hold ? bin_q      : '0;
   assign load_lvl_o    = in_hold ? load_lvl_q : '0;
   assign base_lvl_o    = in_hold ? base_lvl_q : '0;

endmodule
